// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, tracks the outstanding memory request, and
// fills the IF/ID register, using a skid buffer for decode stalls and squashing on redirects.
module fetch_stage #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Instr_In,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic              ifid_valid
);

  localparam logic [ADDR_W-1:0] Step = ADDR_W'(PC_STEP);

  typedef enum logic [0:0] {StRun, StStalled} state_e;

  state_e             r_state, w_state_next;
  logic [ADDR_W-1:0]  r_pc, w_pc_next;
  logic [ADDR_W-1:0]  r_req_pc, w_req_pc_next;
  logic               r_req_valid, w_req_valid_next;
  logic [DATA_W-1:0]  r_hold_instr, w_hold_instr_next;
  logic [DATA_W-1:0]  r_ifid_instr, w_ifid_instr_next;
  logic [ADDR_W-1:0]  r_ifid_pc, w_ifid_pc_next;
  logic [ADDR_W-1:0]  r_ifid_pc_plus4, w_ifid_pc_plus4_next;
  logic               r_ifid_valid, w_ifid_valid_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= StRun;
      r_pc            <= RESET_PC;
      r_req_pc        <= '0;
      r_req_valid     <= 1'b0;
      r_hold_instr    <= '0;
      r_ifid_instr    <= '0;
      r_ifid_pc       <= '0;
      r_ifid_pc_plus4 <= '0;
      r_ifid_valid    <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_pc            <= w_pc_next;
      r_req_pc        <= w_req_pc_next;
      r_req_valid     <= w_req_valid_next;
      r_hold_instr    <= w_hold_instr_next;
      r_ifid_instr    <= w_ifid_instr_next;
      r_ifid_pc       <= w_ifid_pc_next;
      r_ifid_pc_plus4 <= w_ifid_pc_plus4_next;
      r_ifid_valid    <= w_ifid_valid_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_pc_next            = r_pc;
    w_req_pc_next        = r_req_pc;
    w_req_valid_next     = r_req_valid;
    w_hold_instr_next    = r_hold_instr;
    w_ifid_instr_next    = r_ifid_instr;
    w_ifid_pc_next       = r_ifid_pc;
    w_ifid_pc_plus4_next = r_ifid_pc_plus4;
    w_ifid_valid_next    = r_ifid_valid;

    if (redirect_valid) begin
      // Squash the in-flight request and IF/ID; stale ifid payload is kept to avoid X.
      w_pc_next         = redirect_pc;
      w_req_valid_next  = 1'b0;
      w_ifid_valid_next = 1'b0;
      w_state_next      = StRun;
    end else begin
      unique case (r_state)
        StRun: begin
          if (stall) begin
            // Memory will re-read mem[pc] next cycle, so park the req_pc instruction.
            w_hold_instr_next = Instr_In;
            w_state_next      = StStalled;
          end else begin
            w_ifid_instr_next    = Instr_In;
            w_ifid_pc_next       = r_req_pc;
            w_ifid_pc_plus4_next = r_req_pc + Step;
            w_ifid_valid_next    = r_req_valid;
            w_pc_next            = r_pc + Step;
            w_req_pc_next        = r_pc;
            w_req_valid_next     = 1'b1;
          end
        end
        StStalled: begin
          if (!stall) begin
            w_ifid_instr_next    = r_hold_instr;
            w_ifid_pc_next       = r_req_pc;
            w_ifid_pc_plus4_next = r_req_pc + Step;
            w_ifid_valid_next    = r_req_valid;
            w_pc_next            = r_pc + Step;
            w_req_pc_next        = r_pc;
            w_req_valid_next     = 1'b1;
            w_state_next         = StRun;
          end
        end
        default: w_state_next = StRun;
      endcase
    end
  end

  assign Addr          = r_pc;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc       = r_ifid_pc;
  assign ifid_pc_plus4 = r_ifid_pc_plus4;
  assign ifid_valid    = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect traffic checked
// against a transaction-level model (PC plus a queue of issued-but-not-decoded addresses).
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] addr, instr_in, ifid_instr, ifid_pc, ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] w_addr, w_instr_in, w_ifid_instr, w_ifid_pc, w_ifid_pc_plus4;
  logic        w_ifid_valid;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .Addr(addr), .Instr_In(instr_in), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid)
  );

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_wrap (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .Addr(w_addr), .Instr_In(w_instr_in),
    .ifid_instr(w_ifid_instr), .ifid_pc(w_ifid_pc), .ifid_pc_plus4(w_ifid_pc_plus4),
    .ifid_valid(w_ifid_valid)
  );

  // Registered-read instruction memories.
  always @(posedge clk) instr_in   <= 32'hA000_0000 + addr;
  always @(posedge clk) w_instr_in <= 32'hA000_0000 + w_addr;

  always #5 clk = ~clk;

  // Reference model: next fetch address, addresses issued but not yet in IF/ID, IF/ID content.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_valid;
  logic [31:0] m_ifid_pc;

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_valid = 1'b0;
    m_ifid_pc = 32'h0;
  endtask

  task automatic model_edge();
    if (redirect_valid) begin
      m_pc = redirect_pc;
      m_q.delete();
      m_valid = 1'b0;
    end else if (!stall) begin
      if (m_q.size() > 0) begin
        m_valid = 1'b1;
        m_ifid_pc = m_q.pop_front();
      end else begin
        m_valid = 1'b0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #1;
    checks += 5;
    if (addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr); end
    if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    if (ifid_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", ifid_pc); end
    if (ifid_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
    if (ifid_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_plus4 got=%h exp=0", ifid_pc_plus4); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_run();
    checks += 2;
    if (addr !== 32'h0) begin failures++; $display("FAIL run_addr0 got=%h exp=0", addr); end
    if (ifid_valid !== 1'b0) begin failures++; $display("FAIL run_valid0 got=%b exp=0", ifid_valid); end
    step();
    checks += 2;
    if (addr !== 32'h4) begin failures++; $display("FAIL run_addr1 got=%h exp=4", addr); end
    if (ifid_valid !== 1'b0) begin failures++; $display("FAIL run_valid1 got=%b exp=0", ifid_valid); end
    step();
    checks += 5;
    if (addr !== 32'h8) begin failures++; $display("FAIL run_addr2 got=%h exp=8", addr); end
    if (ifid_valid !== 1'b1) begin failures++; $display("FAIL run_valid2 got=%b exp=1", ifid_valid); end
    if (ifid_pc !== 32'h0) begin failures++; $display("FAIL run_pc got=%h exp=0", ifid_pc); end
    if (ifid_instr !== 32'hA000_0000) begin
      failures++; $display("FAIL run_instr got=%h exp=a0000000", ifid_instr);
    end
    if (ifid_pc_plus4 !== 32'h4) begin failures++; $display("FAIL run_plus4 got=%h exp=4", ifid_pc_plus4); end
    step();
    step();
  endtask

  task automatic test_stall();
    checks += 2;
    if (ifid_pc !== 32'h8) begin failures++; $display("FAIL stall_pre_pc got=%h exp=8", ifid_pc); end
    if (addr !== 32'h10) begin failures++; $display("FAIL stall_pre_addr got=%h exp=10", addr); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (addr !== 32'h10) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=10", i, addr); end
      if (ifid_pc !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=8", i, ifid_pc); end
      if (ifid_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, ifid_valid); end
    end
    stall = 1'b0;
    step();
    checks += 3;
    if (ifid_pc !== 32'hC) begin failures++; $display("FAIL skid_pc got=%h exp=c", ifid_pc); end
    if (ifid_instr !== 32'hA000_000C) begin
      failures++; $display("FAIL skid_instr got=%h exp=a000000c", ifid_instr);
    end
    if (addr !== 32'h14) begin failures++; $display("FAIL skid_addr got=%h exp=14", addr); end
    step();
    checks += 2;
    if (ifid_pc !== 32'h10) begin failures++; $display("FAIL skid_next_pc got=%h exp=10", ifid_pc); end
    if (ifid_instr !== 32'hA000_0010) begin
      failures++; $display("FAIL skid_next_instr got=%h exp=a0000010", ifid_instr);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    checks += 2;
    if (addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", addr); end
    if (ifid_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble1 got=%b exp=0", ifid_valid); end
    step();
    checks += 1;
    if (ifid_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble2 got=%b exp=0", ifid_valid); end
    step();
    checks += 4;
    if (ifid_valid !== 1'b1) begin failures++; $display("FAIL redir_valid got=%b exp=1", ifid_valid); end
    if (ifid_pc !== 32'h100) begin failures++; $display("FAIL redir_pc got=%h exp=100", ifid_pc); end
    if (ifid_instr !== 32'hA000_0100) begin
      failures++; $display("FAIL redir_instr got=%h exp=a0000100", ifid_instr);
    end
    if (ifid_pc_plus4 !== 32'h104) begin
      failures++; $display("FAIL redir_plus4 got=%h exp=104", ifid_pc_plus4);
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    checks += 2;
    if (addr !== 32'h40) begin failures++; $display("FAIL rs_addr got=%h exp=40", addr); end
    if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rs_bubble1 got=%b exp=0", ifid_valid); end
    step();
    checks += 2;
    if (addr !== 32'h44) begin failures++; $display("FAIL rs_addr2 got=%h exp=44", addr); end
    if (ifid_valid !== 1'b0) begin failures++; $display("FAIL rs_bubble2 got=%b exp=0", ifid_valid); end
    step();
    checks += 3;
    if (ifid_valid !== 1'b1) begin failures++; $display("FAIL rs_valid got=%b exp=1", ifid_valid); end
    if (ifid_pc !== 32'h40) begin failures++; $display("FAIL rs_pc got=%h exp=40", ifid_pc); end
    if (ifid_instr !== 32'hA000_0040) begin
      failures++; $display("FAIL rs_instr got=%h exp=a0000040", ifid_instr);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    checks += 1;
    if (w_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffff8", w_addr); end
    step();
    checks += 1;
    if (w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr1 got=%h exp=fffffffc", w_addr); end
    step();
    checks += 3;
    if (w_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr2 got=%h exp=0", w_addr); end
    if (w_ifid_pc !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", w_ifid_pc); end
    if (w_ifid_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", w_ifid_valid); end
    step();
    checks += 3;
    if (w_ifid_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", w_ifid_pc); end
    if (w_ifid_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=0", w_ifid_pc_plus4); end
    if (w_ifid_instr !== 32'h9FFF_FFFC) begin
      failures++; $display("FAIL wrap_instr got=%h exp=9ffffffc", w_ifid_instr);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step();
    stall = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    stall = 1'b0;
    model_reset();
    #1;
    checks += 2;
    if (addr !== 32'h0) begin failures++; $display("FAIL areset_addr got=%h exp=0", addr); end
    if (ifid_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", ifid_valid); end
    #2;
    reset = 1'b0;
    step();
    checks += 1;
    if (addr !== 32'h4) begin failures++; $display("FAIL areset_resume_addr got=%h exp=4", addr); end
    step();
    checks += 2;
    if (ifid_valid !== 1'b1) begin failures++; $display("FAIL areset_resume_valid got=%b exp=1", ifid_valid); end
    if (ifid_pc !== 32'h0) begin failures++; $display("FAIL areset_resume_pc got=%h exp=0", ifid_pc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      step();
      checks += 2;
      if (addr !== m_pc) begin
        failures++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, addr, m_pc);
      end
      if (ifid_valid !== m_valid) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, ifid_valid, m_valid);
      end
      if (m_valid) begin
        checks += 3;
        if (ifid_pc !== m_ifid_pc) begin
          failures++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", c, ifid_pc, m_ifid_pc);
        end
        if (ifid_instr !== 32'hA000_0000 + m_ifid_pc) begin
          failures++;
          $display("FAIL rand_instr cyc=%0d got=%h exp=%h", c, ifid_instr, 32'hA000_0000 + m_ifid_pc);
        end
        if (ifid_pc_plus4 !== m_ifid_pc + 32'd4) begin
          failures++;
          $display("FAIL rand_plus4 cyc=%0d got=%h exp=%h", c, ifid_pc_plus4, m_ifid_pc + 32'd4);
        end
      end
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    #1;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end of the pipelined MIPS core. It owns the program counter and drives Addr into Instruction_Mem. It captures that memory's registered instruction output (1-cycle read latency) into the IF/ID pipeline register consumed by decode. It handles decode stalls with a skid buffer and branch/jump redirects with squash.

Parameters:
ADDR_W, 32, width of PC / instruction address
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per sequential fetch

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
stall  input  1  decode hazard; hold PC and IF/ID
redirect_valid  input  1  taken branch/jump from later stage; squash and reload PC
redirect_pc  input  ADDR_W  target address, sampled when redirect_valid=1
Addr  output  ADDR_W  fetch address to Instruction_Mem (equals pc register)
Instr_In  input  DATA_W  Instruction_Mem Out_Reg; holds mem[Addr sampled at previous edge]
ifid_instr  output  DATA_W  IF/ID instruction
ifid_pc  output  ADDR_W  PC of ifid_instr
ifid_pc_plus4  output  ADDR_W  ifid_pc + PC_STEP (registered)
ifid_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async): pc=RESET_PC, Addr=RESET_PC, req_pc=0, req_valid=0, hold_instr=0, state=RUN, ifid_instr=0, ifid_pc=0, ifid_pc_plus4=0, ifid_valid=0. Reset asserted mid-stall or mid-redirect clears everything with no clock edge needed.
- Request tracking: at each non-stalled edge, memory latches Addr=pc. In the same edge: req_pc<=pc, req_valid<=1. During the following cycle, Instr_In = instruction at req_pc.
- Latency: an address on Addr at edge n appears in IF/ID after edge n+1, so ifid_valid is 1 two edges after the address first issues.
- First IF/ID after reset release: ifid_valid=0. Bubble comes from req_valid=0.
- States RUN, STALLED.
- RUN, stall=0, redirect_valid=0:
  - pc<=pc+PC_STEP
  - IF/ID<={Instr_In, req_pc, req_pc+PC_STEP, req_valid}
- RUN, stall=1:
  - hold_instr<=Instr_In; go STALLED.
  - pc, req_pc, req_valid and IF/ID hold.
  - Addr stays constant, so memory now re-reads mem[pc], not mem[req_pc]; the skid buffer preserves the req_pc instruction.
- STALLED, stall=1: hold everything.
- STALLED, stall=0:
  - IF/ID<={hold_instr, req_pc, req_pc+PC_STEP, req_valid}
  - pc<=pc+PC_STEP, req_pc<=pc, req_valid<=1; go RUN.
  - Instr_In next cycle is mem[old pc], which is correct.
- redirect_valid=1 (any state): has priority over stall.
  - pc<=redirect_pc, req_valid<=0, ifid_valid<=0; go RUN.
  - ifid_instr/ifid_pc values are don't-care but must not X-propagate; keep previous values.
  - Penalty is 2 bubbles; redirect_pc reaches IF/ID two edges later.
- Consecutive redirects: each one restarts the sequence; the last one wins.
- Arithmetic: pc+PC_STEP is modulo 2^ADDR_W and wraps silently. No alignment check; redirect_pc is used as given.
- No combinational path from inputs to outputs; all outputs come directly from registers.

Test Plan:
- Bench memory model: registered read, Out_Reg = 32'hA000_0000 + Addr.
- Reset then run: hold reset 10 ns, release, run freely.
  - Addr = 0x0, 0x4, 0x8 on successive cycles.
  - First ifid_valid=1 on 2nd edge after release, with ifid_pc=0x0, ifid_instr=0xA000_0000, ifid_pc_plus4=0x4.
- Stall skid: assert stall for 3 cycles while ifid_pc=0x8 (req_pc=0xC, Addr=0x10).
  - Addr holds 0x10 and IF/ID holds 0x8 throughout.
  - After release, ifid_pc sequence is 0xC (instr 0xA000_000C), then 0x10. No duplicate, no loss.
- Redirect: redirect_valid=1, redirect_pc=0x100 while Addr=0x14.
  - Next Addr=0x100.
  - ifid_valid=0 for 2 edges, then ifid_pc=0x100, ifid_instr=0xA000_0100.
- Redirect during stall: stall=1 and redirect_valid=1 (redirect_pc=0x40) in the same cycle.
  - Redirect wins: Addr=0x40, state RUN.
  - With stall then low, ifid_pc=0x40 arrives 2 edges later.
- Wrap: RESET_PC=32'hFFFF_FFF8.
  - Addr = FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - IF/ID entry for FFFF_FFFC has ifid_pc_plus4=0x0.
- Async reset mid-stall: pulse reset between clock edges while STALLED.
  - ifid_valid=0 and Addr=RESET_PC immediately, before the next edge.
  - Normal fetch from RESET_PC resumes after release.
